// File: rtl/dom_pkg.sv
// Shared constants and types for the DOM d=5 share encoder and its LFSR helper.
package dom_pkg;

  localparam int SHARES    = 6;
  localparam int RAND_BITS = 15;
  localparam int LFSR_W    = 31;

  localparam int TAP_HI = 30;
  localparam int TAP_LO = 27;

  // An all-zero seed would lock the LFSR, so it is replaced by this value.
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 31'h1;

  typedef enum logic [1:0] {
    ST_SEED    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/dom_lfsr_unroll.sv
// Combinational N-step advance of the Fibonacci LFSR (taps 30/27).
// Also returns the N successive feedback bits.
module dom_lfsr_unroll
  import dom_pkg::*;
#(
  parameter int N = 25
) (
  input  logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] next_state,
  output logic [N-1:0]      bits
);

  always_comb begin : unroll
    logic [LFSR_W-1:0] s;
    logic              f;
    s    = state;
    f    = 1'b0;
    bits = '0;
    for (int i = 0; i < N; i++) begin
      f       = s[TAP_HI] ^ s[TAP_LO];
      bits[i] = f;
      s       = {s[LFSR_W-2:0], f};
    end
    next_state = s;
  end

endmodule

// File: rtl/dom_share_encoder.sv
// Splits unmasked bit pairs into 6 Boolean shares and supplies the 15 DOM gate random bits.
// It also tracks the gate's 1-cycle latency and enforces a reseed after RESEED_PERIOD transfers.
module dom_share_encoder #(
  parameter int SHARES        = 6,
  parameter int RAND_BITS     = 15,
  parameter int LFSR_W        = 31,
  parameter int RESEED_PERIOD = 1024
) (
  input  logic                 clock_0,
  input  logic                 reset_0,
  input  logic                 seed_valid,
  input  logic [LFSR_W-1:0]    seed,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 x0,
  input  logic                 x1,
  output logic [SHARES-1:0]    i0_shares,
  output logic [SHARES-1:0]    i1_shares,
  output logic [RAND_BITS-1:0] p_rand,
  output logic                 out_valid,
  output logic                 and_valid,
  output logic                 reseed_req
);

  import dom_pkg::*;

  localparam int          MASK_BITS = SHARES - 1;
  localparam int          NR        = 2 * MASK_BITS + RAND_BITS;
  localparam logic [15:0] PERIOD    = RESEED_PERIOD[15:0];

  state_t                state;
  logic [LFSR_W-1:0]     lfsr;
  logic [LFSR_W-1:0]     lfsr_adv;
  logic [NR-1:0]         r;
  logic [15:0]           count;
  logic                  xfer;
  logic [SHARES-1:0]     enc_i0;
  logic [SHARES-1:0]     enc_i1;
  logic [RAND_BITS-1:0]  enc_p;

  assign in_ready   = (state == ST_RUN) && !seed_valid;
  assign xfer       = in_valid && in_ready;
  assign reseed_req = (state != ST_RUN);

  dom_lfsr_unroll #(.N(NR)) u_unroll (
    .state      (lfsr),
    .next_state (lfsr_adv),
    .bits       (r)
  );

  // Share 0 absorbs the plain bit and the XOR of that operand's masks only.
  assign enc_i0 = {r[MASK_BITS-1:0], x0 ^ (^r[MASK_BITS-1:0])};
  assign enc_i1 = {r[2*MASK_BITS-1:MASK_BITS], x1 ^ (^r[2*MASK_BITS-1:MASK_BITS])};
  assign enc_p  = r[2*MASK_BITS +: RAND_BITS];

  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      state <= ST_SEED;
      lfsr  <= '0;
      count <= '0;
    end else if (seed_valid) begin
      state <= ST_RUN;
      lfsr  <= (seed == '0) ? ZERO_SEED_SUB : seed;
      count <= '0;
    end else if (xfer) begin
      lfsr <= lfsr_adv;
      if (count != PERIOD) count <= count + 16'd1;
      if (count + 16'd1 == PERIOD) state <= ST_EXPIRED;
    end
  end

  // Encoding register stage; and_valid mirrors the gate's own register stage.
  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      i0_shares <= '0;
      i1_shares <= '0;
      p_rand    <= '0;
      out_valid <= 1'b0;
      and_valid <= 1'b0;
    end else begin
      out_valid <= xfer;
      and_valid <= out_valid;
      if (xfer) begin
        i0_shares <= enc_i0;
        i1_shares <= enc_i1;
        p_rand    <= enc_p;
      end
    end
  end

endmodule

// File: tb/tb_dom_share_encoder.sv
// Scoreboard bench for dom_share_encoder with a short reseed period.
module tb_dom_share_encoder;
  import dom_pkg::*;

  localparam int RP = 4;

  logic        clock_0 = 1'b0;
  logic        reset_0 = 1'b1;
  logic        seed_valid = 1'b0;
  logic [30:0] seed = '0;
  logic        in_valid = 1'b0;
  logic        x0 = 1'b0;
  logic        x1 = 1'b0;
  logic        in_ready;
  logic [5:0]  i0_shares;
  logic [5:0]  i1_shares;
  logic [14:0] p_rand;
  logic        out_valid;
  logic        and_valid;
  logic        reseed_req;

  dom_share_encoder #(.RESEED_PERIOD(RP)) dut (
    .clock_0    (clock_0),
    .reset_0    (reset_0),
    .seed_valid (seed_valid),
    .seed       (seed),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x0         (x0),
    .x1         (x1),
    .i0_shares  (i0_shares),
    .i1_shares  (i1_shares),
    .p_rand     (p_rand),
    .out_valid  (out_valid),
    .and_valid  (and_valid),
    .reseed_req (reseed_req)
  );

  always #5 clock_0 = ~clock_0;

  typedef struct packed {
    logic        x0;
    logic        x1;
    logic [5:0]  i0;
    logic [5:0]  i1;
    logic [14:0] p;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_hold;
  state_t      m_state;
  logic [30:0] m_lfsr;
  int          m_count;
  logic        m_ov;
  logic        m_av;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t encode(input logic [30:0] s, input logic a, input logic b,
                                  output logic [30:0] ns);
    exp_t        e;
    logic [24:0] rr;
    logic        f;
    for (int i = 0; i < 25; i++) begin
      f     = s[30] ^ s[27];
      rr[i] = f;
      s     = {s[29:0], f};
    end
    ns   = s;
    e.x0 = a;
    e.x1 = b;
    e.i0 = {rr[4:0], a ^ (^rr[4:0])};
    e.i1 = {rr[9:5], b ^ (^rr[9:5])};
    e.p  = rr[24:10];
    return e;
  endfunction

  // Reference model of the encoder, updated on the same edges as the DUT.
  always @(posedge clock_0 or negedge reset_0) begin : model
    logic        xf;
    logic [30:0] nl;
    exp_t        e;
    if (!reset_0) begin
      m_state = ST_SEED;
      m_lfsr  = '0;
      m_count = 0;
      m_ov    = 1'b0;
      m_av    = 1'b0;
      m_hold  = '0;
      sb.delete();
    end else begin
      xf   = in_valid && (m_state == ST_RUN) && !seed_valid;
      m_av = m_ov;
      m_ov = xf;
      if (seed_valid) begin
        m_state = ST_RUN;
        m_lfsr  = (seed == 31'd0) ? 31'd1 : seed;
        m_count = 0;
      end else if (xf) begin
        e      = encode(m_lfsr, x0, x1, nl);
        m_lfsr = nl;
        sb.push_back(e);
        m_hold = e;
        m_count++;
        if (m_count == RP) m_state = ST_EXPIRED;
      end
    end
  end

  always @(negedge clock_0) begin : monitor
    exp_t e;
    chk("in_ready", in_ready, (m_state == ST_RUN) && !seed_valid);
    chk("reseed_req", reseed_req, m_state != ST_RUN);
    chk("out_valid", out_valid, m_ov);
    chk("and_valid", and_valid, m_av);
    if (out_valid) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("i0_shares", i0_shares, e.i0);
        chk("i1_shares", i1_shares, e.i1);
        chk("p_rand", p_rand, e.p);
        chk("x0_recombine", ^i0_shares, e.x0);
        chk("x1_recombine", ^i1_shares, e.x1);
      end
    end else begin
      chk("hold", {p_rand, i1_shares, i0_shares}, {m_hold.p, m_hold.i1, m_hold.i0});
    end
  end

  task automatic tick();
    @(posedge clock_0);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_i0"}, i0_shares, 0);
    chk({tag, "_i1"}, i1_shares, 0);
    chk({tag, "_p"}, p_rand, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_av"}, and_valid, 0);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_reseed"}, reseed_req, 1);
    chk({tag, "_state"}, dut.state, ST_SEED);
    chk({tag, "_lfsr"}, dut.lfsr, 0);
    chk({tag, "_count"}, dut.count, 0);
  endtask

  task automatic transfers(input int n);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      x0 = 1'($urandom);
      x1 = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic load_seed(input logic [30:0] s);
    seed_valid = 1'b1;
    seed       = s;
    tick();
    seed_valid = 1'b0;
  endtask

  initial begin
    logic [30:0] new_seed;
    #1 reset_0 = 1'b0;
    #2 check_reset_outputs("rst");
    repeat (2) @(posedge clock_0);
    #1 reset_0 = 1'b1;

    // No seed yet: requests are refused.
    in_valid = 1'b1;
    repeat (20) tick();
    chk("noseed_ready", in_ready, 0);

    // Seed 1 while in_valid stays high: the seed cycle itself carries no transfer.
    load_seed(31'h1);
    transfers(RP);

    // Expired: held in_valid is refused and the count stays saturated.
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("exp_count", dut.count, RP);
    chk("exp_ready", in_ready, 0);
    chk("exp_reseed", reseed_req, 1);
    chk("exp_state", dut.state, ST_EXPIRED);

    // Zero seed behaves as seed 1.
    load_seed(31'h0);
    chk("zseed_lfsr", dut.lfsr, 31'h1);
    transfers(2);

    // Seed and request in the same RUN cycle.
    new_seed   = 31'($urandom) | 31'h1;
    seed_valid = 1'b1;
    seed       = new_seed;
    in_valid   = 1'b1;
    tick();
    seed_valid = 1'b0;
    in_valid   = 1'b0;
    chk("both_ov", out_valid, 0);
    chk("both_lfsr", dut.lfsr, new_seed);
    chk("both_count", dut.count, 0);
    chk("both_state", dut.state, ST_RUN);

    // Idle gap, then resume from the unadvanced LFSR.
    repeat (5) tick();
    chk("idle_lfsr", dut.lfsr, new_seed);
    transfers(2);
    tick();

    // Asynchronous reset between edges while out_valid is high.
    in_valid = 1'b1;
    x0 = 1'b1;
    x1 = 1'b0;
    tick();
    chk("pre_rst_ov", out_valid, 1);
    #1 reset_0 = 1'b0;
    #1 check_reset_outputs("async_rst");
    in_valid = 1'b0;
    repeat (2) tick();
    reset_0 = 1'b1;

    // Fresh seed after reset, full period back-to-back.
    load_seed(31'h5a5a_1234);
    transfers(RP);
    tick();
    chk("final_state", dut.state, ST_EXPIRED);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
